// File: rtl/wb_cache_param_pkg.sv
// Shared widths, FSM state encodings and address helpers for the parametrised write-back cache.
package cache_pkg;

  localparam int unsigned ADDR_W_DEF         = 10;
  localparam int unsigned WORD_W_DEF         = 10;
  localparam int unsigned WORDS_PER_LINE_DEF = 2;
  localparam int unsigned LINES_DEF          = 16;
  localparam int unsigned OFF_W_DEF          = $clog2(WORDS_PER_LINE_DEF);
  localparam int unsigned IDX_W_DEF          = $clog2(LINES_DEF);
  localparam int unsigned TAG_W_DEF          = ADDR_W_DEF - IDX_W_DEF - OFF_W_DEF;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_LOOKUP     = 3'd1;
  localparam state_t S_WRITEBACK  = 3'd2;
  localparam state_t S_ALLOCATE   = 3'd3;
  localparam state_t S_FLUSH_SCAN = 3'd4;
  localparam state_t S_FLUSH_WB   = 3'd5;

  // Extract a w-bit field starting at bit lo.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int unsigned lo,
                                             input int unsigned w);
    return (addr >> lo) & ((32'd1 << w) - 32'd1);
  endfunction

  // Compose a line address {tag, idx}.
  function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] idx,
                                            input int unsigned idx_w);
    return (tag << idx_w) | idx;
  endfunction

endpackage

// File: rtl/wb_cache_param_if.sv
// CPU, flush and line-memory signals of the cache; slave = cache side, master = CPU/RAM side.
interface wb_cache_param_if #(
  parameter int unsigned ADDR_W         = cache_pkg::ADDR_W_DEF,
  parameter int unsigned WORD_W         = cache_pkg::WORD_W_DEF,
  parameter int unsigned WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE_DEF
);
  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;

  logic                    cpu_req;
  logic                    cpu_we;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [WORD_W-1:0]       cpu_wdata;
  logic                    cpu_ready;
  logic                    cpu_done;
  logic [WORD_W-1:0]       cpu_rdata;
  logic                    flush_req;
  logic                    flush_done;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_W-OFF_W-1:0] mem_addr;
  logic [LINE_W-1:0]       mem_wdata;
  logic [LINE_W-1:0]       mem_rdata;
  logic                    mem_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush_req, mem_rdata, mem_ready,
    output cpu_ready, cpu_done, cpu_rdata, flush_done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush_req, mem_rdata, mem_ready,
    input  cpu_ready, cpu_done, cpu_rdata, flush_done, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/wb_cache_param_line_store.sv
// Valid/dirty/tag/data arrays with a combinational read port and registered install/merge/clear.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned WORD_W         = WORD_W_DEF,
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int unsigned LINES          = LINES_DEF,
  parameter int unsigned TAG_W          = TAG_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [$clog2(LINES)-1:0]          idx,
  output logic                              rd_valid,
  output logic                              rd_dirty,
  output logic [TAG_W-1:0]                  rd_tag,
  output logic [WORD_W*WORDS_PER_LINE-1:0]  rd_line,
  input  logic                              install_en,
  input  logic [TAG_W-1:0]                  install_tag,
  input  logic [WORD_W*WORDS_PER_LINE-1:0]  install_line,
  input  logic                              merge_en,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] merge_off,
  input  logic [WORD_W-1:0]                 merge_word,
  input  logic                              clear_en
);
  localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  // Only the status bits are reset; tags and data are qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (install_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (merge_en) begin
      dirty_q[idx] <= 1'b1;
    end else if (clear_en) begin
      valid_q[idx] <= 1'b0;
      dirty_q[idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (install_en) begin
      tag_q[idx]  <= install_tag;
      data_q[idx] <= install_line;
    end else if (merge_en) begin
      data_q[idx][WORD_W*32'(merge_off) +: WORD_W] <= merge_word;
    end
  end

endmodule

// File: rtl/wb_cache_param.sv
// Direct-mapped write-back, write-allocate cache with whole-cache flush.
// Defining CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module wb_cache_param
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned WORD_W         = WORD_W_DEF,
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int unsigned LINES          = LINES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  wb_cache_param_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
`endif
);
  localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W   = $clog2(LINES);
  localparam int unsigned TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINE_W  = WORD_W * WORDS_PER_LINE;
  localparam int unsigned LADDR_W = ADDR_W - OFF_W;

  state_t             state_q, state_d;
  logic               req_we_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [WORD_W-1:0]  req_wdata_q;
  logic [IDX_W-1:0]   scan_q, scan_d;
  logic               accept;

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx, st_idx;
  logic [OFF_W-1:0]   req_off;
  logic               rd_valid, rd_dirty, hit, last_line;
  logic [TAG_W-1:0]   rd_tag;
  logic [LINE_W-1:0]  rd_line;
  logic               install_en, merge_en, clear_en;

  logic               cpu_ready_q, cpu_done_q, cpu_done_d, flush_done_q, flush_done_d;
  logic [WORD_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [LADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;

  assign req_tag   = TAG_W'(addr_field(32'(req_addr_q), OFF_W + IDX_W, TAG_W));
  assign req_idx   = IDX_W'(addr_field(32'(req_addr_q), OFF_W, IDX_W));
  assign req_off   = OFF_W'(addr_field(32'(req_addr_q), 0, OFF_W));
  assign st_idx    = (state_q == S_FLUSH_SCAN || state_q == S_FLUSH_WB) ? scan_q : req_idx;
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign last_line = (scan_q == IDX_W'(LINES - 1));

  cache_line_store #(
    .WORD_W(WORD_W), .WORDS_PER_LINE(WORDS_PER_LINE), .LINES(LINES), .TAG_W(TAG_W)
  ) u_store (
    .clk(clk), .rst(rst), .idx(st_idx),
    .rd_valid(rd_valid), .rd_dirty(rd_dirty), .rd_tag(rd_tag), .rd_line(rd_line),
    .install_en(install_en), .install_tag(req_tag), .install_line(bus.mem_rdata),
    .merge_en(merge_en), .merge_off(req_off), .merge_word(req_wdata_q),
    .clear_en(clear_en)
  );

  // Next state, store write strobes and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    accept       = 1'b0;
    install_en   = 1'b0;
    merge_en     = 1'b0;
    clear_en     = 1'b0;
    cpu_done_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    flush_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end else if (bus.flush_req) begin
          scan_d  = '0;
          state_d = S_FLUSH_SCAN;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          cpu_done_d = 1'b1;
          if (req_we_q) merge_en = 1'b1;
          else          cpu_rdata_d = rd_line[WORD_W*32'(req_off) +: WORD_W];
          state_d = S_IDLE;
        end else if (rd_valid && rd_dirty) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_WRITEBACK: if (bus.mem_ready) state_d = S_ALLOCATE;
      S_ALLOCATE: begin
        if (bus.mem_ready) begin
          install_en = 1'b1;
          state_d    = S_LOOKUP;
        end
      end
      S_FLUSH_SCAN: begin
        if (rd_valid && rd_dirty) begin
          state_d = S_FLUSH_WB;
        end else begin
          clear_en = 1'b1;
          if (last_line) begin
            flush_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            scan_d = scan_q + IDX_W'(1);
          end
        end
      end
      S_FLUSH_WB: begin
        // The last line finishes straight away rather than wrapping the scan index.
        if (bus.mem_ready) begin
          clear_en = 1'b1;
          if (last_line) begin
            flush_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            scan_d  = scan_q + IDX_W'(1);
            state_d = S_FLUSH_SCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_d   = (state_d == S_WRITEBACK) || (state_d == S_ALLOCATE) || (state_d == S_FLUSH_WB);
    mem_we_d    = (state_d == S_WRITEBACK) || (state_d == S_FLUSH_WB);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (mem_we_d) begin
      mem_addr_d  = LADDR_W'(line_addr(32'(rd_tag), 32'(st_idx), IDX_W));
      mem_wdata_d = rd_line;
    end else if (mem_req_d) begin
      mem_addr_d  = LADDR_W'(line_addr(32'(req_tag), 32'(req_idx), IDX_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      scan_q       <= '0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      cpu_ready_q  <= 1'b1;
      cpu_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      flush_done_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      if (accept) begin
        req_we_q    <= bus.cpu_we;
        req_addr_q  <= bus.cpu_addr;
        req_wdata_q <= bus.cpu_wdata;
      end
      cpu_ready_q  <= (state_d == S_IDLE);
      cpu_done_q   <= cpu_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      flush_done_q <= flush_done_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.cpu_ready  = cpu_ready_q;
  assign bus.cpu_done   = cpu_done_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.flush_done = flush_done_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

`ifdef CACHE_STATS_EN
  // Counted only on the first lookup of a request, never on the post-fill re-lookup.
  logic first_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      first_q <= 1'b1;
    end else if (state_q == S_LOOKUP) begin
      first_q <= 1'b0;
      if (first_q && hit && hit_count != 16'hFFFF)    hit_count  <= hit_count + 16'd1;
      if (first_q && !hit && miss_count != 16'hFFFF)  miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_cache_param.sv
// Directed self-checking bench for wb_cache_param with a line-wide RAM responder.
module tb_wb_cache_param;

  localparam int MEM_LAT = 2;

  typedef struct packed {
    logic        we;
    logic [8:0]  addr;
    logic [19:0] data;
  } tx_t;

  logic clk;
  logic rst;
  logic mem_hold;
  int   tests_run;
  int   failed;
  logic [19:0] ram [512];
  tx_t  txq [$];

  wb_cache_param_if #(.ADDR_W(10), .WORD_W(10), .WORDS_PER_LINE(2)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  wb_cache_param #(.ADDR_W(10), .WORD_W(10), .WORDS_PER_LINE(2), .LINES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count));
`else
  wb_cache_param #(.ADDR_W(10), .WORD_W(10), .WORDS_PER_LINE(2), .LINES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: answers each transaction MEM_LAT cycles after mem_req rises.
  initial begin
    int  cnt;
    tx_t t;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (bus.mem_req && !mem_hold && !rst) begin
        cnt++;
        if (cnt >= MEM_LAT) begin
          cnt = 0;
          bus.mem_ready = 1'b1;
          t.we   = bus.mem_we;
          t.addr = bus.mem_addr;
          t.data = bus.mem_we ? bus.mem_wdata : 20'd0;
          if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = ram[bus.mem_addr];
          txq.push_back(t);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic cpu_access(input logic we, input logic [9:0] addr, input logic [9:0] wdata,
                            output logic [9:0] rdata, output int lat);
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(posedge clk);
    #1;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = ~addr;
    bus.cpu_wdata = ~wdata;
    lat   = 0;
    rdata = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_done) begin
        rdata = bus.cpu_rdata;
        break;
      end
    end
    tests_run++;
    if (bus.cpu_done !== 1'b1) begin
      failed++;
      $display("FAIL access_timeout addr=%0d: cpu_done=%b expected 1", addr, bus.cpu_done);
    end
  endtask

  task automatic do_flush(output int lat);
    @(negedge clk);
    bus.flush_req = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (bus.flush_done) break;
    end
    tests_run++;
    if (bus.flush_done !== 1'b1) begin
      failed++;
      $display("FAIL flush_timeout: flush_done=%b expected 1", bus.flush_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.cpu_ready !== 1'b1) begin failed++; $display("FAIL rst_cpu_ready: got %b expected 1", bus.cpu_ready); end
    tests_run++; if (bus.cpu_done !== 1'b0) begin failed++; $display("FAIL rst_cpu_done: got %b expected 0", bus.cpu_done); end
    tests_run++; if (bus.cpu_rdata !== 10'd0) begin failed++; $display("FAIL rst_cpu_rdata: got %0d expected 0", bus.cpu_rdata); end
    tests_run++; if (bus.flush_done !== 1'b0) begin failed++; $display("FAIL rst_flush_done: got %b expected 0", bus.flush_done); end
    tests_run++; if (bus.mem_req !== 1'b0) begin failed++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
    tests_run++; if (bus.mem_we !== 1'b0) begin failed++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
    tests_run++; if (bus.mem_addr !== 9'd0) begin failed++; $display("FAIL rst_mem_addr: got %0d expected 0", bus.mem_addr); end
    tests_run++; if (bus.mem_wdata !== 20'd0) begin failed++; $display("FAIL rst_mem_wdata: got %0h expected 0", bus.mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_read_fill();
    logic [9:0] rd;
    int lat;
    txq.delete();
    cpu_access(1'b0, 10'd50, 10'd0, rd, lat);
    tests_run++; if (rd !== 10'd5) begin failed++; $display("FAIL fill_rdata: got %0d expected 5", rd); end
    tests_run++; if (lat != 5) begin failed++; $display("FAIL fill_latency: got %0d expected 5", lat); end
    tests_run++; if (txq.size() != 1) begin failed++; $display("FAIL fill_txn_count: got %0d expected 1", txq.size()); end
    else if (txq[0].we !== 1'b0 || txq[0].addr !== 9'd25) begin
      failed++; $display("FAIL fill_txn: got we=%b addr=%0d expected we=0 addr=25", txq[0].we, txq[0].addr);
    end
    txq.delete();
    cpu_access(1'b0, 10'd51, 10'd0, rd, lat);
    tests_run++; if (rd !== 10'd7) begin failed++; $display("FAIL hit_rdata: got %0d expected 7", rd); end
    tests_run++; if (lat != 2) begin failed++; $display("FAIL hit_latency: got %0d expected 2", lat); end
    tests_run++; if (txq.size() != 0) begin failed++; $display("FAIL hit_txn_count: got %0d expected 0", txq.size()); end
  endtask

  task automatic test_writeback();
    logic [9:0]  rd;
    logic [19:0] exp_wb;
    int lat;
    exp_wb = {10'd7, 10'd300};
    cpu_access(1'b1, 10'd50, 10'd300, rd, lat);
    tests_run++; if (lat != 2) begin failed++; $display("FAIL write_hit_latency: got %0d expected 2", lat); end
    txq.delete();
    cpu_access(1'b0, 10'd562, 10'd0, rd, lat);
    tests_run++; if (rd !== 10'd11) begin failed++; $display("FAIL dirty_miss_rdata: got %0d expected 11", rd); end
    tests_run++; if (lat != 7) begin failed++; $display("FAIL dirty_miss_latency: got %0d expected 7", lat); end
    tests_run++; if (txq.size() != 2) begin failed++; $display("FAIL wb_txn_count: got %0d expected 2", txq.size()); end
    else begin
      if (txq[0].we !== 1'b1 || txq[0].addr !== 9'd25 || txq[0].data !== exp_wb) begin
        failed++; $display("FAIL wb_txn: got we=%b addr=%0d data=%0h expected we=1 addr=25 data=%0h",
                           txq[0].we, txq[0].addr, txq[0].data, exp_wb);
      end
      tests_run++;
      if (txq[1].we !== 1'b0 || txq[1].addr !== 9'd281) begin
        failed++; $display("FAIL wb_fill_txn: got we=%b addr=%0d expected we=0 addr=281", txq[1].we, txq[1].addr);
      end
    end
  endtask

  task automatic test_write_miss();
    logic [9:0] rd;
    int lat;
    txq.delete();
    cpu_access(1'b1, 10'd84, 10'd400, rd, lat);
    tests_run++; if (lat != 5) begin failed++; $display("FAIL write_miss_latency: got %0d expected 5", lat); end
    tests_run++; if (txq.size() != 1) begin failed++; $display("FAIL write_miss_txn_count: got %0d expected 1", txq.size()); end
    else if (txq[0].we !== 1'b0 || txq[0].addr !== 9'd42) begin
      failed++; $display("FAIL write_miss_txn: got we=%b addr=%0d expected we=0 addr=42", txq[0].we, txq[0].addr);
    end
    cpu_access(1'b0, 10'd84, 10'd0, rd, lat);
    tests_run++; if (rd !== 10'd400) begin failed++; $display("FAIL merged_rdata: got %0d expected 400", rd); end
    tests_run++; if (lat != 2) begin failed++; $display("FAIL merged_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_flush();
    logic [9:0]  rd;
    logic [19:0] exp9, exp10;
    int lat;
    exp9  = {10'd22, 10'd123};
    exp10 = {10'd33, 10'd400};
    cpu_access(1'b1, 10'd562, 10'd123, rd, lat);
    txq.delete();
    do_flush(lat);
    @(negedge clk);
    tests_run++; if (bus.flush_done !== 1'b0) begin failed++; $display("FAIL flush_done_pulse: got %b expected 0", bus.flush_done); end
    tests_run++; if (txq.size() != 2) begin failed++; $display("FAIL flush_txn_count: got %0d expected 2", txq.size()); end
    else begin
      if (txq[0].we !== 1'b1 || txq[0].addr !== 9'd281 || txq[0].data !== exp9) begin
        failed++; $display("FAIL flush_wb0: got we=%b addr=%0d data=%0h expected we=1 addr=281 data=%0h",
                           txq[0].we, txq[0].addr, txq[0].data, exp9);
      end
      tests_run++;
      if (txq[1].we !== 1'b1 || txq[1].addr !== 9'd42 || txq[1].data !== exp10) begin
        failed++; $display("FAIL flush_wb1: got we=%b addr=%0d data=%0h expected we=1 addr=42 data=%0h",
                           txq[1].we, txq[1].addr, txq[1].data, exp10);
      end
    end
    txq.delete();
    do_flush(lat);
    tests_run++; if (lat != 17) begin failed++; $display("FAIL clean_flush_latency: got %0d expected 17", lat); end
    tests_run++; if (txq.size() != 0) begin failed++; $display("FAIL clean_flush_txn_count: got %0d expected 0", txq.size()); end
    txq.delete();
    cpu_access(1'b0, 10'd51, 10'd0, rd, lat);
    tests_run++; if (rd !== 10'd7 || lat != 5 || txq.size() != 1) begin
      failed++; $display("FAIL post_flush_miss51: got rdata=%0d lat=%0d txns=%0d expected 7 5 1", rd, lat, txq.size());
    end
    txq.delete();
    cpu_access(1'b0, 10'd84, 10'd0, rd, lat);
    tests_run++; if (rd !== 10'd400 || lat != 5 || txq.size() != 1) begin
      failed++; $display("FAIL post_flush_miss84: got rdata=%0d lat=%0d txns=%0d expected 400 5 1", rd, lat, txq.size());
    end
  endtask

  task automatic test_reset_abort();
    logic [9:0] rd;
    int lat;
    mem_hold = 1'b1;
    txq.delete();
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 10'd100;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 9'd50) begin
      failed++; $display("FAIL abort_alloc: got req=%b we=%b addr=%0d expected 1 0 50", bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (bus.mem_req !== 1'b0) begin failed++; $display("FAIL abort_mem_req: got %b expected 0", bus.mem_req); end
    tests_run++; if (bus.mem_addr !== 9'd0) begin failed++; $display("FAIL abort_mem_addr: got %0d expected 0", bus.mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    mem_hold = 1'b0;
    #1;
    tests_run++; if (bus.cpu_ready !== 1'b1 || bus.cpu_done !== 1'b0) begin
      failed++; $display("FAIL abort_ready: got ready=%b done=%b expected 1 0", bus.cpu_ready, bus.cpu_done);
    end
    cpu_access(1'b0, 10'd100, 10'd0, rd, lat);
    tests_run++; if (rd !== 10'd55 || lat != 5 || txq.size() != 1) begin
      failed++; $display("FAIL abort_reread: got rdata=%0d lat=%0d txns=%0d expected 55 5 1", rd, lat, txq.size());
    end
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    logic [9:0] rd;
    int lat;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      failed++; $display("FAIL stats_reset: got hits=%0d misses=%0d expected 0 0", hit_count, miss_count);
    end
    cpu_access(1'b0, 10'd50, 10'd0, rd, lat);
    cpu_access(1'b0, 10'd51, 10'd0, rd, lat);
    cpu_access(1'b0, 10'd50, 10'd0, rd, lat);
    cpu_access(1'b1, 10'd51, 10'd9, rd, lat);
    cpu_access(1'b0, 10'd562, 10'd0, rd, lat);
    tests_run++; if (hit_count !== 16'd3) begin failed++; $display("FAIL stats_hits: got %0d expected 3", hit_count); end
    tests_run++; if (miss_count !== 16'd2) begin failed++; $display("FAIL stats_misses: got %0d expected 2", miss_count); end
  endtask
`endif

  initial begin
    tests_run     = 0;
    failed        = 0;
    mem_hold      = 1'b0;
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.flush_req = 1'b0;
    for (int i = 0; i < 512; i++) ram[i] = 20'd0;
    ram[25]  = {10'd7, 10'd5};
    ram[281] = {10'd22, 10'd11};
    ram[42]  = {10'd33, 10'd44};
    ram[50]  = {10'd66, 10'd55};

    test_reset();
    test_read_fill();
    test_writeback();
    test_write_miss();
    test_flush();
    test_reset_abort();
`ifdef CACHE_STATS_EN
    test_stats();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
